// File: rtl/ps2_host_transmitter_if.sv
// Host-side command handshake between the system logic and the PS/2 transmitter.
interface ps2_host_transmitter_if;
  logic       txStart;
  logic [7:0] txData;
  logic       txBusy;
  logic       txDone;
  logic       txAckOk;
  logic       txError;

  modport master (
    output txStart,
    output txData,
    input  txBusy,
    input  txDone,
    input  txAckOk,
    input  txError
  );

  modport slave (
    input  txStart,
    input  txData,
    output txBusy,
    output txDone,
    output txAckOk,
    output txError
  );
endinterface

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame driven on device
// clock falling edges, ack check, with start and transfer timeouts.
module ps2_host_transmitter #(
  parameter int unsigned CLOCK_FREQUNCY   = 100000000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned XFER_TIMEOUT_US  = 2000
) (
  input  logic                   clk,
  input  logic                   rst,
  ps2_host_transmitter_if.slave  host,
  input  logic                   ps2Clk,
  input  logic                   ps2Data,
  output logic                   ps2ClkOe,
  output logic                   ps2DataOe
);

  localparam int unsigned CYCLES_PER_US  = CLOCK_FREQUNCY / 1000000;
  localparam int unsigned INHIBIT_CYCLES = CYCLES_PER_US * INHIBIT_US;
  localparam int unsigned START_CYCLES   = CYCLES_PER_US * START_TIMEOUT_US;
  localparam int unsigned XFER_CYCLES    = CYCLES_PER_US * XFER_TIMEOUT_US;
  localparam int unsigned MAX_IS         = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int unsigned MAX_CYCLES     = (MAX_IS > XFER_CYCLES) ? MAX_IS : XFER_CYCLES;
  localparam int unsigned TIMER_W        = $clog2(MAX_CYCLES + 1);
  localparam int unsigned BIT_W          = 4;
  localparam int unsigned FRAME_W        = 9;

  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_CYCLES - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST    = TIMER_W'(XFER_CYCLES - 1);
  localparam logic [BIT_W-1:0]   STOP_SENT    = BIT_W'(10);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    WAIT_FIRST,
    SHIFT,
    WAIT_IDLE,
    FAIL
  } state_t;

  state_t               state, stateNext;
  logic [TIMER_W-1:0]   timer, timerNext;
  logic [BIT_W-1:0]     bitCount, bitCountNext;
  logic [FRAME_W-1:0]   shiftReg, shiftRegNext;
  logic [1:0]           clkSync, dataSync;
  logic                 clkPrev;
  logic                 clkLine, dataLine, fallEdge;
  logic                 ps2ClkOeNext, ps2DataOeNext;
  logic                 txBusyQ, txDoneQ, txAckOkQ, txErrorQ;
  logic                 txBusyNext, txDoneNext, txAckOkNext, txErrorNext;

  // Two-flop synchronizers; idle-high reset values avoid a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
      clkPrev  <= 1'b1;
    end else begin
      clkSync  <= {clkSync[0], ps2Clk};
      dataSync <= {dataSync[0], ps2Data};
      clkPrev  <= clkSync[1];
    end
  end

  assign clkLine  = clkSync[1];
  assign dataLine = dataSync[1];
  assign fallEdge = clkPrev & ~clkLine;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      bitCount  <= '0;
      shiftReg  <= '0;
      ps2ClkOe  <= 1'b0;
      ps2DataOe <= 1'b0;
      txBusyQ   <= 1'b0;
      txDoneQ   <= 1'b0;
      txAckOkQ  <= 1'b0;
      txErrorQ  <= 1'b0;
    end else begin
      state     <= stateNext;
      timer     <= timerNext;
      bitCount  <= bitCountNext;
      shiftReg  <= shiftRegNext;
      ps2ClkOe  <= ps2ClkOeNext;
      ps2DataOe <= ps2DataOeNext;
      txBusyQ   <= txBusyNext;
      txDoneQ   <= txDoneNext;
      txAckOkQ  <= txAckOkNext;
      txErrorQ  <= txErrorNext;
    end
  end

  // Next-state and next-output logic; shiftReg holds {parity, data} and fills with 1 so
  // the tenth edge naturally releases the data line for the stop bit.
  always_comb begin
    stateNext     = state;
    timerNext     = timer + TIMER_W'(1);
    bitCountNext  = bitCount;
    shiftRegNext  = shiftReg;
    ps2DataOeNext = ps2DataOe;
    txDoneNext    = 1'b0;
    txAckOkNext   = txAckOkQ;
    txErrorNext   = txErrorQ;

    case (state)
      IDLE: begin
        timerNext     = '0;
        ps2DataOeNext = 1'b0;
        if (host.txStart) begin
          stateNext    = INHIBIT;
          shiftRegNext = {~^host.txData, host.txData};
          txAckOkNext  = 1'b0;
          txErrorNext  = 1'b0;
        end
      end
      INHIBIT: begin
        if (timer == INHIBIT_LAST) begin
          stateNext     = REQUEST;
          ps2DataOeNext = 1'b1;
        end
      end
      REQUEST: begin
        stateNext = WAIT_FIRST;
        timerNext = '0;
      end
      WAIT_FIRST: begin
        if (timer == START_LAST) begin
          stateNext = FAIL;
        end else if (fallEdge) begin
          stateNext     = SHIFT;
          timerNext     = '0;
          ps2DataOeNext = ~shiftReg[0];
          shiftRegNext  = {1'b1, shiftReg[FRAME_W-1:1]};
          bitCountNext  = BIT_W'(1);
        end
      end
      SHIFT: begin
        // Timeout takes priority over a coincident falling edge.
        if (timer == XFER_LAST) begin
          stateNext = FAIL;
        end else if (fallEdge) begin
          bitCountNext = bitCount + BIT_W'(1);
          if (bitCount == STOP_SENT) begin
            if (!dataLine) begin
              txAckOkNext = 1'b1;
              stateNext   = WAIT_IDLE;
            end else begin
              stateNext = FAIL;
            end
          end else begin
            ps2DataOeNext = ~shiftReg[0];
            shiftRegNext  = {1'b1, shiftReg[FRAME_W-1:1]};
          end
        end
      end
      WAIT_IDLE: begin
        ps2DataOeNext = 1'b0;
        if (timer == XFER_LAST) begin
          stateNext = FAIL;
        end else if (clkLine && dataLine) begin
          stateNext  = IDLE;
          txDoneNext = 1'b1;
        end
      end
      FAIL: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    if (stateNext == FAIL) begin
      ps2DataOeNext = 1'b0;
      txDoneNext    = 1'b1;
      txErrorNext   = 1'b1;
    end

    ps2ClkOeNext = (stateNext == INHIBIT) || (stateNext == REQUEST);
    txBusyNext   = (stateNext != IDLE);
  end

  assign host.txBusy  = txBusyQ;
  assign host.txDone  = txDoneQ;
  assign host.txAckOk = txAckOkQ;
  assign host.txError = txErrorQ;

endmodule
